ar_ordering_unit: RTL and testbench

Sits directly downstream of the incoming AR request buffer and upstream of the AXI slave. It allocates a unique transaction tag from a pool of NUM_TAGS slots for every accepted AR request. It records the original ID and burst length in a tag table, then forwards the request through a registered output stage with `id` replaced by the tag. The response/ROB path resolves tags back to original IDs through a combinational lookup port and frees each tag on a release port.

---
 rtl/rob_pkg.sv | 32 +++
 rtl/ar_if.sv | 21 ++
 rtl/tag_free_list.sv | 63 ++++++
 rtl/ar_ordering_unit.sv | 119 +++++++++++
 tb/tb_ar_ordering_unit.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rob_pkg.sv
// Shared types and helpers for the AR ordering unit and the R-path ROB.
package rob_pkg;

    localparam int ID_W_DEF    = 32;
    localparam int ADDR_W_DEF  = 32;
    localparam int LEN_W_DEF   = 8;
    localparam int SIZE_W_DEF  = 3;
    localparam int BURST_W_DEF = 2;
    localparam int QOS_W_DEF   = 4;

    // Full AR request as carried through the ordering stage.
    typedef struct packed {
        logic [ID_W_DEF-1:0]    id;
        logic [ADDR_W_DEF-1:0]  addr;
        logic [LEN_W_DEF-1:0]   len;
        logic [SIZE_W_DEF-1:0]  size;
        logic [BURST_W_DEF-1:0] burst;
        logic [QOS_W_DEF-1:0]   qos;
    } ar_entry_t;

    // What the response path needs to recover per outstanding tag.
    typedef struct packed {
        logic [ID_W_DEF-1:0]  id;
        logic [LEN_W_DEF-1:0] len;
    } tag_entry_t;

    // Bit width of an index into n slots, never less than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 32'sd2) ? 32'sd1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ar_if.sv
// AR channel bundle: valid/ready handshake plus request fields.
interface ar_if #(
    parameter int ID_WIDTH    = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int LEN_WIDTH   = 8,
    parameter int SIZE_WIDTH  = 3,
    parameter int BURST_WIDTH = 2,
    parameter int QOS_WIDTH   = 4
) ();
    logic                   valid;
    logic                   ready;
    logic [ID_WIDTH-1:0]    id;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [LEN_WIDTH-1:0]   len;
    logic [SIZE_WIDTH-1:0]  size;
    logic [BURST_WIDTH-1:0] burst;
    logic [QOS_WIDTH-1:0]   qos;

    modport sender   (output valid, id, addr, len, size, burst, qos, input  ready);
    modport receiver (input  valid, id, addr, len, size, burst, qos, output ready);
endinterface

// File: rtl/tag_free_list.sv
// Pool of NUM_TAGS tags: free bitmap, lowest-free selection and free count.
// A release only takes effect next cycle, so allocation never sees it early.
module tag_free_list import rob_pkg::*; #(
    parameter int NUM_TAGS = 16,
    parameter int TAG_W    = clog2_min1(NUM_TAGS),
    parameter int CNT_W    = $clog2(NUM_TAGS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alloc_en,
    output logic [TAG_W-1:0]    alloc_tag,
    input  logic                rel_valid,
    input  logic [TAG_W-1:0]    rel_tag,
    output logic [NUM_TAGS-1:0] free_mask,
    output logic [CNT_W-1:0]    free_cnt
);
    logic [NUM_TAGS-1:0] free_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [TAG_W-1:0]    low_tag_s;
    logic                rel_eff_s;
    logic [NUM_TAGS-1:0] rel_mask_s;
    logic [NUM_TAGS-1:0] alloc_mask_s;

    // Priority encoder: scanning downward leaves the lowest free index.
    always_comb begin
        low_tag_s = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (free_r[i]) low_tag_s = TAG_W'(i);
            else           low_tag_s = low_tag_s;
        end
    end

    // One-hot masks for this cycle's release and allocation.
    always_comb begin
        rel_eff_s    = rel_valid & ~free_r[rel_tag];
        rel_mask_s   = '0;
        alloc_mask_s = '0;
        if (rel_eff_s) rel_mask_s[rel_tag] = 1'b1;
        else           rel_mask_s = '0;
        if (alloc_en)  alloc_mask_s[low_tag_s] = 1'b1;
        else           alloc_mask_s = '0;
    end

    // Bitmap and counter update; duplicate releases change nothing.
    always_ff @(posedge clk) begin
        if (rst) begin
            free_r <= '1;
            cnt_r  <= CNT_W'(NUM_TAGS);
        end else begin
            free_r <= (free_r | rel_mask_s) & ~alloc_mask_s;
            case ({alloc_en, rel_eff_s})
                2'b10:   cnt_r <= cnt_r - CNT_W'(1);
                2'b01:   cnt_r <= cnt_r + CNT_W'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    assign alloc_tag = low_tag_s;
    assign free_mask = free_r;
    assign free_cnt  = cnt_r;

endmodule

// File: rtl/ar_ordering_unit.sv
// Tags every accepted AR request, remembers its original id/len and
// forwards it through a one-entry output register with id replaced by the tag.
module ar_ordering_unit import rob_pkg::*; #(
    parameter int ID_WIDTH    = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int LEN_WIDTH   = 8,
    parameter int SIZE_WIDTH  = 3,
    parameter int BURST_WIDTH = 2,
    parameter int QOS_WIDTH   = 4,
    parameter int NUM_TAGS    = 16,
    localparam int TAG_W      = clog2_min1(NUM_TAGS),
    localparam int CNT_W      = $clog2(NUM_TAGS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    ar_if.receiver               ar_in,
    ar_if.sender                 ar_out,
    input  logic                 rel_valid,
    input  logic [TAG_W-1:0]     rel_tag,
    input  logic [TAG_W-1:0]     lu_tag,
    output logic                 lu_valid,
    output logic [ID_WIDTH-1:0]  lu_id,
    output logic [LEN_WIDTH-1:0] lu_len,
    output logic [CNT_W-1:0]     free_cnt,
    output logic                 idle
);
    logic [TAG_W-1:0]       alloc_tag_s;
    logic [NUM_TAGS-1:0]    free_mask_s;
    logic [CNT_W-1:0]       free_cnt_s;
    logic                   accept_s;
    logic                   pop_s;

    logic                   out_valid_r;
    logic [ID_WIDTH-1:0]    out_id_r;
    logic [ADDR_WIDTH-1:0]  out_addr_r;
    logic [LEN_WIDTH-1:0]   out_len_r;
    logic [SIZE_WIDTH-1:0]  out_size_r;
    logic [BURST_WIDTH-1:0] out_burst_r;
    logic [QOS_WIDTH-1:0]   out_qos_r;

    logic [ID_WIDTH-1:0]    tbl_id_r  [NUM_TAGS];
    logic [LEN_WIDTH-1:0]   tbl_len_r [NUM_TAGS];

    tag_free_list #(
        .NUM_TAGS (NUM_TAGS),
        .TAG_W    (TAG_W),
        .CNT_W    (CNT_W)
    ) u_free_list (
        .clk       (clk),
        .rst       (rst),
        .alloc_en  (accept_s),
        .alloc_tag (alloc_tag_s),
        .rel_valid (rel_valid),
        .rel_tag   (rel_tag),
        .free_mask (free_mask_s),
        .free_cnt  (free_cnt_s)
    );

    // Ready needs a free tag and room in the output register (or a pop now).
    assign ar_in.ready = (|free_mask_s) & (~out_valid_r | ar_out.ready);
    assign accept_s    = ar_in.valid & ar_in.ready;
    assign pop_s       = out_valid_r & ar_out.ready;

    // Output register: loads on accept (also when popping), clears on a bare pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_id_r    <= '0;
            out_addr_r  <= '0;
            out_len_r   <= '0;
            out_size_r  <= '0;
            out_burst_r <= '0;
            out_qos_r   <= '0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            out_id_r    <= ID_WIDTH'(alloc_tag_s);
            out_addr_r  <= ar_in.addr;
            out_len_r   <= ar_in.len;
            out_size_r  <= ar_in.size;
            out_burst_r <= ar_in.burst;
            out_qos_r   <= ar_in.qos;
        end else if (pop_s) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Tag table write; contents of free slots are never observed.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            tbl_id_r[alloc_tag_s]  <= ar_in.id;
            tbl_len_r[alloc_tag_s] <= ar_in.len;
        end
    end

    // Lookup from registered state, so a same-cycle write shows next cycle.
    always_comb begin
        lu_valid = ~free_mask_s[lu_tag];
        if (lu_valid) begin
            lu_id  = tbl_id_r[lu_tag];
            lu_len = tbl_len_r[lu_tag];
        end else begin
            lu_id  = '0;
            lu_len = '0;
        end
    end

    assign ar_out.valid = out_valid_r;
    assign ar_out.id    = out_id_r;
    assign ar_out.addr  = out_addr_r;
    assign ar_out.len   = out_len_r;
    assign ar_out.size  = out_size_r;
    assign ar_out.burst = out_burst_r;
    assign ar_out.qos   = out_qos_r;
    assign free_cnt     = free_cnt_s;
    assign idle         = (free_cnt_s == CNT_W'(NUM_TAGS)) & ~out_valid_r;

endmodule

// File: tb/tb_ar_ordering_unit.sv
// Randomised bench for ar_ordering_unit with a set-based reference model.
module tb_ar_ordering_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rel_valid = 1'b0;
    logic [3:0]  rel_tag = 4'd0;
    logic [3:0]  lu_tag = 4'd0;
    logic        lu_valid;
    logic [31:0] lu_id;
    logic [7:0]  lu_len;
    logic [4:0]  free_cnt;
    logic        idle;
    int          errors = 0;
    int          checks = 0;

    ar_if #(.ID_WIDTH(32), .ADDR_WIDTH(32), .LEN_WIDTH(8)) in_if ();
    ar_if #(.ID_WIDTH(32), .ADDR_WIDTH(32), .LEN_WIDTH(8)) out_if ();

    ar_ordering_unit #(.NUM_TAGS(16)) dut (
        .clk(clk), .rst(rst), .ar_in(in_if), .ar_out(out_if),
        .rel_valid(rel_valid), .rel_tag(rel_tag), .lu_tag(lu_tag),
        .lu_valid(lu_valid), .lu_id(lu_id), .lu_len(lu_len),
        .free_cnt(free_cnt), .idle(idle)
    );

    always #5 clk = ~clk;

    // Reference model: set of free tags, per-tag record, pending output.
    bit          m_free [16];
    logic [31:0] m_id   [16];
    logic [7:0]  m_len  [16];
    bit          m_ov;
    logic [31:0] m_oid, m_oaddr;
    logic [7:0]  m_olen;
    logic [2:0]  m_osize;
    logic [1:0]  m_oburst;
    logic [3:0]  m_oqos;

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < 16; i++) if (m_free[i]) n++;
        return n;
    endfunction

    function automatic int m_lowest();
        for (int i = 0; i < 16; i++) if (m_free[i]) return i;
        return -1;
    endfunction

    function automatic bit m_ready();
        return (m_count() > 0) && (!m_ov || out_if.ready);
    endfunction

    function automatic bit m_idle();
        return (m_count() == 16) && !m_ov;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 16; i++) m_free[i] = 1'b1;
        m_ov = 1'b0; m_oid = '0; m_oaddr = '0; m_olen = '0;
        m_osize = '0; m_oburst = '0; m_oqos = '0;
    endtask

    // Advance one clock, updating the model from the inputs seen at the edge.
    task automatic cycle();
        bit acc, pop, rel;
        int t;
        acc = in_if.valid && m_ready();
        pop = m_ov && out_if.ready;
        rel = rel_valid && !m_free[rel_tag];
        t   = m_lowest();
        @(posedge clk);
        if (rst) begin
            m_reset();
        end else begin
            if (rel) m_free[rel_tag] = 1'b1;
            if (acc) begin
                m_free[t] = 1'b0;
                m_id[t] = in_if.id; m_len[t] = in_if.len;
                m_ov = 1'b1; m_oid = 32'(t); m_oaddr = in_if.addr; m_olen = in_if.len;
                m_osize = in_if.size; m_oburst = in_if.burst; m_oqos = in_if.qos;
            end else if (pop) begin
                m_ov = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic drive_ar(input logic v, input logic [31:0] id, input logic [7:0] len);
        in_if.valid = v; in_if.id = id; in_if.len = len;
        in_if.addr = $urandom; in_if.size = 3'($urandom); in_if.burst = 2'($urandom);
        in_if.qos = 4'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1; cycle(); cycle(); rst = 1'b0; #1;
        checks++; if (in_if.ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_if.ready); end
        checks++; if (free_cnt !== 5'd16) begin errors++; $display("FAIL reset_free_cnt: got %0d want 16", free_cnt); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b want 1", idle); end
        checks++; if (out_if.valid !== 1'b0 || out_if.addr !== 32'h0 || out_if.id !== 32'h0)
            begin errors++; $display("FAIL reset_out: got v=%b id=%h addr=%h want 0", out_if.valid, out_if.id, out_if.addr); end
        checks++; if (lu_valid !== 1'b0 || lu_id !== 32'h0) begin errors++; $display("FAIL reset_lu: got v=%b id=%h want 0", lu_valid, lu_id); end
    endtask

    task automatic test_single();
        out_if.ready = 1'b1; lu_tag = 4'd0;
        drive_ar(1'b1, 32'h1234, 8'd3); #1;
        checks++; if (lu_valid !== 1'b0) begin errors++; $display("FAIL single_lu_old: got %b want 0", lu_valid); end
        cycle(); in_if.valid = 1'b0; #1;
        checks++; if (out_if.valid !== 1'b1 || out_if.id !== 32'h0 || out_if.addr !== m_oaddr || out_if.len !== 8'd3)
            begin errors++; $display("FAIL single_out: got v=%b id=%h addr=%h len=%0d want 1/0/%h/3", out_if.valid, out_if.id, out_if.addr, out_if.len, m_oaddr); end
        checks++; if (lu_valid !== 1'b1 || lu_id !== 32'h1234 || lu_len !== 8'd3)
            begin errors++; $display("FAIL single_lu: got v=%b id=%h len=%0d want 1/1234/3", lu_valid, lu_id, lu_len); end
        checks++; if (free_cnt !== 5'd15) begin errors++; $display("FAIL single_free_cnt: got %0d want 15", free_cnt); end
        cycle();
        rel_valid = 1'b1; rel_tag = 4'd0; cycle(); rel_valid = 1'b0;
    endtask

    task automatic test_fill();
        out_if.ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive_ar(1'b1, $urandom, 8'($urandom)); #1;
            checks++; if (in_if.ready !== 1'b1) begin errors++; $display("FAIL fill_ready[%0d]: got %b want 1", i, in_if.ready); end
            cycle(); #1;
            checks++; if (out_if.valid !== 1'b1 || out_if.id !== 32'(i))
                begin errors++; $display("FAIL fill_tag[%0d]: got v=%b id=%0d want 1/%0d", i, out_if.valid, out_if.id, i); end
        end
        drive_ar(1'b1, 32'hdead, 8'd1); #1;
        checks++; if (in_if.ready !== 1'b0) begin errors++; $display("FAIL fill_ready17: got %b want 0", in_if.ready); end
        checks++; if (free_cnt !== 5'd0) begin errors++; $display("FAIL fill_free_cnt: got %0d want 0", free_cnt); end
        checks++; if (idle !== 1'b0) begin errors++; $display("FAIL fill_idle: got %b want 0", idle); end
        in_if.valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            lu_tag = 4'(i); #1;
            checks++; if (lu_valid !== 1'b1 || lu_id !== m_id[i] || lu_len !== m_len[i])
                begin errors++; $display("FAIL fill_lu[%0d]: got %b/%h/%0d want 1/%h/%0d", i, lu_valid, lu_id, lu_len, m_id[i], m_len[i]); end
        end
    endtask

    task automatic test_release_full();
        rel_valid = 1'b1; rel_tag = 4'd5; drive_ar(1'b1, 32'hbeef, 8'd2); #1;
        checks++; if (in_if.ready !== 1'b0) begin errors++; $display("FAIL relfull_same_cycle: got %b want 0", in_if.ready); end
        cycle(); rel_valid = 1'b0; #1;
        checks++; if (free_cnt !== 5'd1 || in_if.ready !== 1'b1)
            begin errors++; $display("FAIL relfull_one: got cnt=%0d rdy=%b want 1/1", free_cnt, in_if.ready); end
        cycle(); in_if.valid = 1'b0; #1;
        checks++; if (out_if.id !== 32'd5 || free_cnt !== 5'd0)
            begin errors++; $display("FAIL relfull_tag5: got id=%0d cnt=%0d want 5/0", out_if.id, free_cnt); end
        rel_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin rel_tag = 4'(i % 16); cycle(); end
        rel_valid = 1'b0; #1;
        checks++; if (free_cnt !== 5'd16 || idle !== 1'b1)
            begin errors++; $display("FAIL relfull_drain: got cnt=%0d idle=%b want 16/1", free_cnt, idle); end
    endtask

    task automatic test_stall();
        logic [31:0] a_addr, b_addr;
        out_if.ready = 1'b0;
        drive_ar(1'b1, 32'h11, 8'd0); a_addr = in_if.addr; cycle();
        drive_ar(1'b1, 32'h22, 8'd7); b_addr = in_if.addr;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (out_if.valid !== 1'b1 || out_if.id !== 32'd0 || out_if.addr !== a_addr || in_if.ready !== 1'b0)
                begin errors++; $display("FAIL stall_hold[%0d]: got v=%b id=%0d addr=%h rdy=%b want 1/0/%h/0", i, out_if.valid, out_if.id, out_if.addr, in_if.ready, a_addr); end
            cycle();
        end
        out_if.ready = 1'b1; #1;
        checks++; if (in_if.ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %b want 1", in_if.ready); end
        cycle(); in_if.valid = 1'b0; #1;
        checks++; if (out_if.valid !== 1'b1 || out_if.id !== 32'd1 || out_if.addr !== b_addr || out_if.len !== 8'd7)
            begin errors++; $display("FAIL stall_next: got v=%b id=%0d addr=%h len=%0d want 1/1/%h/7", out_if.valid, out_if.id, out_if.addr, out_if.len, b_addr); end
        cycle();
        rel_valid = 1'b1; rel_tag = 4'd0; cycle(); rel_tag = 4'd1; cycle(); rel_valid = 1'b0;
    endtask

    task automatic test_same_cycle();
        out_if.ready = 1'b1;
        drive_ar(1'b1, 32'h33, 8'd1); cycle();
        rel_valid = 1'b1; rel_tag = 4'd0; drive_ar(1'b1, 32'h44, 8'd2); #1;
        checks++; if (free_cnt !== 5'd15) begin errors++; $display("FAIL same_before: got %0d want 15", free_cnt); end
        cycle(); in_if.valid = 1'b0; #1;
        checks++; if (free_cnt !== 5'd15 || out_if.id !== 32'd1)
            begin errors++; $display("FAIL same_acc_rel: got cnt=%0d id=%0d want 15/1", free_cnt, out_if.id); end
        cycle(); #1;
        checks++; if (free_cnt !== 5'd15) begin errors++; $display("FAIL same_dup_rel: got %0d want 15", free_cnt); end
        rel_tag = 4'd1; cycle(); rel_valid = 1'b0; #1;
        checks++; if (free_cnt !== 5'd16) begin errors++; $display("FAIL same_final: got %0d want 16", free_cnt); end
    endtask

    task automatic test_reset_mid();
        out_if.ready = 1'b1;
        for (int i = 0; i < 8; i++) begin drive_ar(1'b1, $urandom, 8'($urandom)); cycle(); end
        in_if.valid = 1'b0; out_if.ready = 1'b0; #1;
        checks++; if (free_cnt !== 5'd8) begin errors++; $display("FAIL mid_pre: got %0d want 8", free_cnt); end
        rst = 1'b1; cycle(); rst = 1'b0; #1;
        checks++; if (free_cnt !== 5'd16 || out_if.valid !== 1'b0 || idle !== 1'b1)
            begin errors++; $display("FAIL mid_reset: got cnt=%0d v=%b idle=%b want 16/0/1", free_cnt, out_if.valid, idle); end
        for (int i = 0; i < 16; i++) begin
            lu_tag = 4'(i); #1;
            checks++; if (lu_valid !== 1'b0) begin errors++; $display("FAIL mid_lu[%0d]: got %b want 0", i, lu_valid); end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive_ar(1'($urandom_range(0, 9) < 6), $urandom, 8'($urandom));
            out_if.ready = 1'($urandom_range(0, 9) < 7);
            rel_valid = 1'($urandom_range(0, 9) < 4);
            rel_tag = 4'($urandom); lu_tag = 4'($urandom); #1;
            checks++; if (in_if.ready !== m_ready()) begin errors++; $display("FAIL rnd_ready[%0d]: got %b want %b", c, in_if.ready, m_ready()); end
            checks++; if (out_if.valid !== m_ov || (m_ov && (out_if.id !== m_oid || out_if.addr !== m_oaddr || out_if.len !== m_olen || out_if.size !== m_osize || out_if.burst !== m_oburst || out_if.qos !== m_oqos)))
                begin errors++; $display("FAIL rnd_out[%0d]: got v=%b id=%0d addr=%h want %b/%0d/%h", c, out_if.valid, out_if.id, out_if.addr, m_ov, m_oid, m_oaddr); end
            checks++; if (lu_valid !== !m_free[lu_tag] || lu_id !== (m_free[lu_tag] ? 32'h0 : m_id[lu_tag]) || lu_len !== (m_free[lu_tag] ? 8'h0 : m_len[lu_tag]))
                begin errors++; $display("FAIL rnd_lu[%0d]: tag %0d got %b/%h/%0d", c, lu_tag, lu_valid, lu_id, lu_len); end
            checks++; if (free_cnt !== 5'(m_count()) || idle !== m_idle())
                begin errors++; $display("FAIL rnd_cnt[%0d]: got %0d/%b want %0d/%b", c, free_cnt, idle, m_count(), m_idle()); end
            cycle();
        end
        in_if.valid = 1'b0; rel_valid = 1'b0;
    endtask

    initial begin
        m_reset();
        drive_ar(1'b0, 32'h0, 8'h0);
        out_if.ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_single();
        test_fill();
        test_release_full();
        test_stall();
        test_same_cycle();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
